// File: rtl/snn_decoder_pkg.sv
// Shared types and helpers for the spike-rate decoder.
package snn_decoder_pkg;

    // Decoder control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned SAT_MAX_BITS = 32;

    // Increment val, clamping at the all-ones value of a `width`-bit counter
    function automatic logic [SAT_MAX_BITS-1:0] sat_inc(
        input logic [SAT_MAX_BITS-1:0] val,
        input int unsigned             width
    );
        logic [SAT_MAX_BITS-1:0] max_val;
        max_val = (width >= SAT_MAX_BITS) ? '1
                : ((SAT_MAX_BITS'(1) << width) - SAT_MAX_BITS'(1));
        return (val >= max_val) ? max_val : (val + SAT_MAX_BITS'(1));
    endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// Single per-neuron saturating spike counter.
module snn_spike_counter
    import snn_decoder_pkg::*;
#(
    parameter int unsigned COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc_en,
    input  logic                  spike,
    output logic [COUNT_BITS-1:0] count
);

    // Clear on decode start, count spikes while accumulating, never wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc_en && spike) begin
            count <= COUNT_BITS'(sat_inc(SAT_MAX_BITS'(count), COUNT_BITS));
        end
    end

endmodule

// File: rtl/snn_spike_decoder.sv
// Rate-coded output decoder: windowed spike counting plus sequential argmax.
// Optional feature macro: SNN_DECODER_READOUT_EN adds count_sel/count_out,
// a combinational readout of any per-neuron counter.
module snn_spike_decoder
    import snn_decoder_pkg::*;
#(
    parameter int unsigned NEURONS     = 8,
    parameter int unsigned COUNT_BITS  = 8,
    parameter int unsigned WINDOW_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NEURONS-1:0]         spikes,
    input  logic [WINDOW_BITS-1:0]     window_len,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NEURONS)-1:0] winner,
    output logic [COUNT_BITS-1:0]      winner_count,
    output logic                       tie
`ifdef SNN_DECODER_READOUT_EN
    ,
    input  logic [$clog2(NEURONS)-1:0] count_sel,
    output logic [COUNT_BITS-1:0]      count_out
`endif
);

    localparam int unsigned      IDX_W    = $clog2(NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   clear_c;
    logic                   inc_en_c;
    logic                   scan_c;

    logic [WINDOW_BITS-1:0] remaining;

    logic [COUNT_BITS-1:0]  counts [NEURONS];

    logic [IDX_W-1:0]       scan_idx;
    logic [COUNT_BITS-1:0]  best;
    logic [IDX_W-1:0]       best_idx;
    logic                   tie_r;

    logic [COUNT_BITS-1:0]  scan_count_c;
    logic [COUNT_BITS-1:0]  cand_best_c;
    logic [IDX_W-1:0]       cand_idx_c;
    logic                   cand_tie_c;

    // Per-neuron spike counters
    for (genvar i = 0; i < NEURONS; i++) begin : g_cnt
        snn_spike_counter #(
            .COUNT_BITS(COUNT_BITS)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (clear_c),
            .inc_en (inc_en_c),
            .spike  (spikes[i]),
            .count  (counts[i])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        clear_c    = 1'b0;
        inc_en_c   = 1'b0;
        scan_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_c    = 1'b1;
                    state_next = (window_len == '0) ? ARGMAX : ACCUM;
                end
            end
            ACCUM: begin
                if (enable) begin
                    inc_en_c = 1'b1;
                    if (remaining == WINDOW_BITS'(1)) begin
                        state_next = ARGMAX;
                    end
                end
            end
            ARGMAX: begin
                scan_c = 1'b1;
                if (scan_idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window counter: loaded on accepted start, counts down on enabled samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (clear_c) begin
            remaining <= window_len;
        end else if (inc_en_c) begin
            remaining <= remaining - WINDOW_BITS'(1);
        end
    end

    // Argmax step: fold the neuron under scan into the running best
    always_comb begin
        scan_count_c = counts[scan_idx];
        cand_best_c  = best;
        cand_idx_c   = best_idx;
        cand_tie_c   = tie_r;
        if (scan_idx == '0) begin
            cand_best_c = scan_count_c;
            cand_idx_c  = '0;
            cand_tie_c  = 1'b0;
        end else if (scan_count_c > best) begin
            cand_best_c = scan_count_c;
            cand_idx_c  = scan_idx;
            cand_tie_c  = 1'b0;
        end else if (scan_count_c == best) begin
            cand_tie_c = 1'b1;
        end
    end

    // Scan registers; index parks at 0 whenever not scanning
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_idx <= '0;
            best     <= '0;
            best_idx <= '0;
            tie_r    <= 1'b0;
        end else if (scan_c) begin
            best     <= cand_best_c;
            best_idx <= cand_idx_c;
            tie_r    <= cand_tie_c;
            scan_idx <= (scan_idx == LAST_IDX) ? '0 : (scan_idx + IDX_W'(1));
        end else begin
            scan_idx <= '0;
        end
    end

    // Status and result registers; results latch on the edge entering DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else begin
            busy <= (state_next == ACCUM) || (state_next == ARGMAX);
            done <= (state_next == DONE);
            if (scan_c && (scan_idx == LAST_IDX)) begin
                winner       <= cand_idx_c;
                winner_count <= cand_best_c;
                tie          <= cand_tie_c;
            end
        end
    end

`ifdef SNN_DECODER_READOUT_EN
    // Debug readout of any counter; out-of-range selects read as zero
    always_comb begin
        count_out = '0;
        if (32'(count_sel) < NEURONS) begin
            count_out = counts[count_sel];
        end
    end
`endif

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Self-checking bench for snn_spike_decoder (directed table + random vs model).
module tb_snn_spike_decoder;

    localparam int unsigned N    = 8;
    localparam int unsigned CB   = 4;
    localparam int unsigned WB   = 8;
    localparam int          MAXC = 600;
    localparam int          CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [N-1:0]  spikes;
    logic [WB-1:0] window_len;
    logic          start;
    logic          busy;
    logic          done;
    logic [2:0]    winner;
    logic [CB-1:0] winner_count;
    logic          tie;
`ifdef SNN_DECODER_READOUT_EN
    logic [2:0]    count_sel;
    logic [CB-1:0] count_out;
`endif

    int total = 0;
    int bad   = 0;

    logic [N-1:0] spk_tab [MAXC];
    logic         en_tab  [MAXC];
    logic         st_tab  [MAXC];
    int           model_cnt [N];

    typedef struct {
        int         w;
        logic [7:0] spk;
        int         en_mode;   // 0: always enabled, 1: 0,1,0,1...
        logic       st_hold;   // hold start high while busy
        int         e_win;
        int         e_cnt;
        int         e_tie;
        int         e_lat;     // edges after the start edge until done is seen
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    snn_spike_decoder #(
        .NEURONS     (N),
        .COUNT_BITS  (CB),
        .WINDOW_BITS (WB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .spikes       (spikes),
        .window_len   (window_len),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .winner_count (winner_count),
        .tie          (tie)
`ifdef SNN_DECODER_READOUT_EN
        ,
        .count_sel    (count_sel),
        .count_out    (count_out)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: per-neuron sums of the sampled vectors, clamped, then argmax
    task automatic model(input int w, output int m_win, output int m_cnt,
                         output int m_tie, output int m_lat);
        int samples;
        int last;
        int holders;
        samples = 0;
        last    = 0;
        for (int n = 0; n < N; n++) model_cnt[n] = 0;
        for (int j = 0; j < MAXC && samples < w; j++) begin
            if (en_tab[j]) begin
                samples++;
                last = j + 1;
                for (int n = 0; n < N; n++)
                    if (spk_tab[j][n]) model_cnt[n] = (model_cnt[n] < CMAX) ? model_cnt[n] + 1 : CMAX;
            end
        end
        m_lat = last + N;
        m_cnt = 0;
        for (int n = 0; n < N; n++) if (model_cnt[n] > m_cnt) m_cnt = model_cnt[n];
        m_win   = -1;
        holders = 0;
        for (int n = 0; n < N; n++) begin
            if (model_cnt[n] == m_cnt) begin
                holders++;
                if (m_win < 0) m_win = n;
            end
        end
        m_tie = (holders > 1) ? 1 : 0;
    endtask

    task automatic check_readout(input string tag);
`ifdef SNN_DECODER_READOUT_EN
        for (int n = 0; n < N; n++) begin
            count_sel = 3'(n);
            #1;
            check({tag, " count_out"}, int'(count_out), model_cnt[n]);
        end
`endif
    endtask

    // One decode: start, feed the tables, wait for done, verify result and hold
    task automatic run(input string tag, input int w, input int e_win, input int e_cnt,
                       input int e_tie, input int e_lat);
        int k;
        bit seen;
        int busy_err;
        window_len = WB'(w);
        start      = 1'b1;
        enable     = 1'($urandom);
        spikes     = N'($urandom);
        tick();
        check({tag, " busy_start"}, int'(busy), 1);
        k        = 0;
        seen     = 1'b0;
        busy_err = 0;
        while (!seen && k < MAXC - 1) begin
            enable     = en_tab[k];
            spikes     = spk_tab[k];
            start      = st_tab[k];
            window_len = WB'($urandom);
            tick();
            k++;
            if (done) begin
                seen = 1'b1;
                if (busy !== 1'b0) busy_err++;
            end else if (busy !== 1'b1) begin
                busy_err++;
            end
        end
        check({tag, " done_lat"}, seen ? k : -1, e_lat);
        check({tag, " busy_profile"}, busy_err, 0);
        check({tag, " winner"}, int'(winner), e_win);
        check({tag, " winner_count"}, int'(winner_count), e_cnt);
        check({tag, " tie"}, int'(tie), e_tie);
        // start during DONE must be ignored
        start      = 1'b1;
        enable     = 1'b1;
        spikes     = '1;
        window_len = WB'(5);
        tick();
        start = 1'b0;
        check({tag, " idle_after"}, int'({busy, done}), 0);
        check({tag, " hold_winner"}, int'(winner), e_win);
        check_readout(tag);
    endtask

    initial begin
        int m_win, m_cnt, m_tie, m_lat;
        int pulses;
        rst_n      = 1'b0;
        start      = 1'b0;
        enable     = 1'b0;
        spikes     = '0;
        window_len = '0;
`ifdef SNN_DECODER_READOUT_EN
        count_sel  = '0;
`endif
        tick();
        tick();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset winner", int'(winner), 0);
        check("reset winner_count", int'(winner_count), 0);
        check("reset tie", int'(tie), 0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("idle no activity", pulses, 0);
        check("idle winner", int'(winner), 0);

        vecs[0] = '{w: 4,  spk: 8'h04, en_mode: 0, st_hold: 1'b0, e_win: 2, e_cnt: 4,  e_tie: 0, e_lat: 12};
        vecs[1] = '{w: 3,  spk: 8'h12, en_mode: 0, st_hold: 1'b0, e_win: 1, e_cnt: 3,  e_tie: 1, e_lat: 11};
        vecs[2] = '{w: 4,  spk: 8'h04, en_mode: 1, st_hold: 1'b1, e_win: 2, e_cnt: 4,  e_tie: 0, e_lat: 16};
        vecs[3] = '{w: 0,  spk: 8'hFF, en_mode: 0, st_hold: 1'b0, e_win: 0, e_cnt: 0,  e_tie: 1, e_lat: 8};
        vecs[4] = '{w: 1,  spk: 8'hFF, en_mode: 0, st_hold: 1'b1, e_win: 0, e_cnt: 1,  e_tie: 1, e_lat: 9};
        vecs[5] = '{w: 16, spk: 8'h60, en_mode: 0, st_hold: 1'b0, e_win: 5, e_cnt: 15, e_tie: 1, e_lat: 24};
        vecs[6] = '{w: 20, spk: 8'h80, en_mode: 0, st_hold: 1'b0, e_win: 7, e_cnt: 15, e_tie: 0, e_lat: 28};

        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < MAXC; j++) begin
                spk_tab[j] = vecs[v].spk;
                en_tab[j]  = (vecs[v].en_mode == 0) ? 1'b1 : 1'(j % 2);
                st_tab[j]  = vecs[v].st_hold;
            end
            model(vecs[v].w, m_win, m_cnt, m_tie, m_lat);
            run($sformatf("vec%0d", v), vecs[v].w, vecs[v].e_win, vecs[v].e_cnt,
                vecs[v].e_tie, vecs[v].e_lat);
        end

        // Reset in the middle of accumulation aborts without a done pulse
        window_len = WB'(10);
        start      = 1'b1;
        enable     = 1'b1;
        spikes     = '1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst winner", int'(winner), 0);
        check("midrst winner_count", int'(winner_count), 0);
        check("midrst tie", int'(tie), 0);
        for (int n = 0; n < N; n++) model_cnt[n] = 0;
        check_readout("midrst");
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("midrst quiet", pulses, 0);

        // Randomized decodes against the model
        for (int r = 0; r < 20; r++) begin
            int w;
            int dens;
            w    = int'($urandom_range(0, 40));
            dens = int'($urandom_range(0, 2));
            for (int j = 0; j < MAXC; j++) begin
                spk_tab[j] = N'($urandom);
                if (dens > 0) spk_tab[j] = spk_tab[j] & N'($urandom);
                if (dens > 1) spk_tab[j] = spk_tab[j] & N'($urandom);
                en_tab[j]  = ($urandom_range(0, 3) != 0);
                st_tab[j]  = 1'($urandom);
            end
            model(w, m_win, m_cnt, m_tie, m_lat);
            run($sformatf("rand%0d", r), w, m_win, m_cnt, m_tie, m_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
